// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Registered prefetch buffer: push/pop/flush, head is zero while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               entry,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush && (count != FULL);
  assign do_pop  = pop && !flush && (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; the head mux hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// Credit-based instruction prefetcher with redirect flush.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic            req_en;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            credit_ok;
  logic            hs;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            pop;
  logic [XLEN-1:0] target;

  // Valid/ready: a request or entry transfers on the rising clock edge where
  // both valid and ready are high; valid never waits on ready.
  assign credit_ok      = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_C;
  assign imem_req_valid = req_en && credit_ok && !redirect_valid;
  assign imem_addr      = fetch_pc;
  assign hs             = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (redirect_valid || discard != '0);
  assign rsp_keep       = imem_rsp_valid && !rsp_drop;
  assign pop            = if_valid && if_ready;
  assign target         = {redirect_pc[XLEN-1:2], 2'b00};
  assign push_entry     = '{pc: rsp_pc, instr: imem_rsp_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      req_en      <= 1'b0;
    end else begin
      req_en      <= 1'b1;
      outstanding <= outstanding + CW'(hs) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        // A response landing in the redirect cycle is dropped here, not counted.
        fetch_pc <= target;
        rsp_pc   <= target;
        discard  <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (hs)       fetch_pc <= fetch_pc + 32'd4;
        if (rsp_keep) rsp_pc   <= rsp_pc + 32'd4;
        if (rsp_drop) discard  <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_keep),
    .entry (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .count (count),
    .head  (head)
  );

  assign if_valid    = (count != '0);
  assign if_instr    = head.instr;
  assign if_pc       = head.pc;
  assign if_pc_plus4 = head.pc + 32'd4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] flushed_now;
  assign flushed_now = (redirect_valid ? (32'(count) - 32'(pop)) : 32'd0) + 32'(rsp_drop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_flushed <= perf_flushed + flushed_now;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order latency memory model.
module tb_instr_fetch_unit;
  localparam logic [31:0] DATA_OFS = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        w_req_valid;
  logic [31:0] w_addr;
  logic        w_if_valid;
  logic [31:0] w_if_instr;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] w_perf_fetched;
  logic [31:0] w_perf_flushed;
`endif

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          lat = 1;
  int          limit = 1000;
  int          hs_cnt = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];
  logic [31:0] w_addrs[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  // Second instance: memory always ready, never responds, decode never consumes.
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .clk(clk), .reset(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_addr(w_addr),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .if_valid(w_if_valid), .if_ready(1'b0), .if_instr(w_if_instr), .if_pc(w_if_pc),
    .if_pc_plus4(w_if_pc_plus4), .redirect_valid(1'b0), .redirect_pc(32'h0)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_perf_fetched), .perf_flushed(w_perf_flushed)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory model: responses in order, lat cycles after the request handshake.
  initial forever begin
    @(posedge clk);
    #2;
    cyc++;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      hs_cnt = 0;
    end else begin
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_addr[0] + DATA_OFS;
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      imem_req_ready = (hs_cnt < limit);
      #1;
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + lat);
        hs_cnt++;
        if (exp_q.size() > 0) check("fetch_addr", imem_addr, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) w_addrs.delete();
    else if (w_req_valid) w_addrs.push_back(w_addr);
  end

  // Driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_if_valid(input string tag);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (if_valid) ok = 1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_pc_plus4", if_pc_plus4, 32'h4);

    // Streaming with zero-wait memory and if_ready=1
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    lat = 1;
    limit = 1000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if_ready = 1'b1;
    @(negedge clk);
    check("pre_first_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_addr, 32'h0);
    wait_if_valid("stream_fill");
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", 32'(if_valid), 32'd1);
      check("stream_pc", if_pc, 32'(i * 4));
      check("stream_pc4", if_pc_plus4, 32'(i * 4 + 4));
      check("stream_instr", if_instr, 32'(i * 4) + DATA_OFS);
      @(negedge clk);
    end

    // Wrap-around start address on the second instance
    check("wrap_count", 32'(w_addrs.size()), 32'd4);
    if (w_addrs.size() == 4) begin
      check("wrap_a0", w_addrs[0], 32'hFFFF_FFF8);
      check("wrap_a1", w_addrs[1], 32'hFFFF_FFFC);
      check("wrap_a2", w_addrs[2], 32'h0000_0000);
      check("wrap_a3", w_addrs[3], 32'h0000_0004);
    end
    check("wrap_req_idle", 32'(w_req_valid), 32'd0);

    // Decode stalled: credit stops fetch at DEPTH requests
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    if_ready = 1'b0;
    do_reset();
    repeat (20) @(negedge clk);
    check("stall_req_count", 32'(hs_cnt), 32'd4);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_if_pc", if_pc, 32'h0);
    @(posedge clk); #1;
    if_ready = 1'b1;
    @(negedge clk);
    check("stall_release_pc0", if_pc, 32'h0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("stall_release_pc", if_pc, 32'(i * 4));
    end

    // Mid-stream reset with a full buffer
    @(posedge clk); #1;
    if_ready = 1'b0;
    repeat (20) @(negedge clk);
    check("full_before_reset", 32'(if_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_if_valid", 32'(if_valid), 32'd0);
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_if_pc", if_pc, 32'h0);
    check("midrst_pc4", if_pc_plus4, 32'h4);
`ifdef FETCH_PERF_CNT_EN
    check("midrst_perf_fetched", perf_fetched, 32'h0);
    check("midrst_perf_flushed", perf_flushed, 32'h0);
`endif

    // 3-cycle latency, two stale requests in flight at redirect
    exp_q.delete();
    lat = 3;
    limit = 2;
    if_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        if (hs_cnt == 2) ok = 1;
      end
      check("two_outstanding", 32'(ok), 32'd1);
    end
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    limit = 1000;
    do_redirect(32'h100);
    @(negedge clk);
    check("redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("redir_req_addr", imem_addr, 32'h100);
    wait_if_valid("redir_fill");
    check("redir_first_pc", if_pc, 32'h100);
    check("redir_first_instr", if_instr, 32'h100 + DATA_OFS);
`ifdef FETCH_PERF_CNT_EN
    check("redir_perf_flushed", perf_flushed, 32'd2);
`endif

    // Unaligned redirect target with a full buffer
    @(posedge clk); #1;
    if_ready = 1'b0;
    lat = 1;
    repeat (20) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(32'h200);
    do_redirect(32'h203);
    @(negedge clk);
    check("align_if_valid", 32'(if_valid), 32'd0);
    check("align_req_valid", 32'(imem_req_valid), 32'd1);
    check("align_req_addr", imem_addr, 32'h200);
`ifdef FETCH_PERF_CNT_EN
    check("align_perf_flushed", perf_flushed, 32'd6);
`endif
    @(posedge clk); #1;
    if_ready = 1'b1;
    wait_if_valid("align_fill");
    check("align_first_pc", if_pc, 32'h200);
    check("align_first_pc4", if_pc_plus4, 32'h204);

    check("addr_queue_drained", 32'(exp_q.size()), 32'd0);
    // Report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch buffer entries, power of two, range 2..16.
REQ-003 SHALL have ports clk (input, 1, clock) and reset (input, 1, asynchronous active-low reset), one clock domain.
REQ-004 SHALL have ports imem_req_valid (output, 1, fetch request) and imem_req_ready (input, 1, memory accepts request).
REQ-005 SHALL have port imem_addr (output, 32, word-aligned fetch address).
REQ-006 SHALL have ports imem_rsp_valid (input, 1, read data returned) and imem_rsp_data (input, 32, instruction word).
REQ-007 SHALL have ports if_valid (output, 1, entry available to decode) and if_ready (input, 1, decode consumes).
REQ-008 SHALL have ports if_instr (output, 32), if_pc (output, 32) and if_pc_plus4 (output, 32): head-entry instruction, PC, PC+4.
REQ-009 SHALL have ports redirect_valid (input, 1, taken branch/jump) and redirect_pc (input, 32, new target).

Function
REQ-010 SHALL require in-order memory responses, each arriving at least one cycle after its request handshake; one response per accepted request.
REQ-011 SHALL assert imem_req_valid when (buffer count + outstanding) < DEPTH and redirect_valid is low.
REQ-012 SHALL hold imem_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-013 SHALL, on request handshake, advance fetch_pc by 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and increment outstanding.
REQ-014 SHALL, on kept response, push {rsp_pc, imem_rsp_data}, advance rsp_pc by 4 and decrement outstanding.
REQ-015 SHALL register the buffer: a pushed entry is visible on if_valid the cycle after the response; no combinational bypass.
REQ-016 SHALL pop the head on if_valid=1 and if_ready=1; simultaneous push and pop SHALL keep count unchanged.
REQ-017 SHALL never overflow, since the credit rule in REQ-011 guarantees space for every outstanding response.
REQ-018 SHALL, on redirect_valid=1, clear the buffer and set fetch_pc and rsp_pc to {redirect_pc[31:2],2'b00}.
REQ-019 SHALL load a discard counter with the in-flight count remaining after the redirect cycle, excluding any response arriving in that cycle.
REQ-020 SHALL drop responses while the discard counter is non-zero, decrementing it per drop.
REQ-021 SHALL deassert if_valid the cycle after redirect; a pop coinciding with redirect SHALL count as consumed.
REQ-022 SHALL present the redirect target on imem_addr with imem_req_valid=1 the cycle after redirect, when credit allows.
REQ-023 SHALL size the outstanding and discard counters at $clog2(DEPTH+1) bits.

Reset
REQ-024 SHALL set on reset assertion: fetch_pc=rsp_pc=RESET_PC, buffer empty, outstanding=discard=0, imem_req_valid=0, if_valid=0, if_instr=if_pc=0, if_pc_plus4=4.
REQ-025 SHALL, on reset assertion mid-operation, abandon in-flight requests; the memory is reset concurrently.
REQ-026 SHALL raise the first request in the first clock edge after reset deassertion.

Configuration
REQ-027 SHALL add, with FETCH_PERF_CNT_EN defined, outputs perf_fetched (32) and perf_flushed (32).
REQ-028 SHALL increment perf_fetched per pop and perf_flushed per discarded response or flushed buffer entry.
REQ-029 SHALL reset both counters to 0 and let them wrap.
REQ-030 SHALL, without FETCH_PERF_CNT_EN, have neither counter, port nor logic.

Structure
REQ-031 SHALL put XLEN=32, INSTR_NOP=32'h0000_0013 and a fetch_entry_t typedef {pc, instr} in package fetch_pkg.
REQ-032 SHALL implement the buffer as sub-module fetch_fifo (push, pop, flush, count, head), instantiated once.

Verification
REQ-033 SHALL test reset release, zero-wait memory and if_ready=1: addresses 0,4,8,...; if_pc 0,4,8 one per cycle after fill; if_pc_plus4 = if_pc+4.
REQ-034 SHALL test if_ready=0 with DEPTH=4: exactly 4 requests issued, then imem_req_valid=0; if_pc stays 0 until if_ready rises.
REQ-035 SHALL test 3-cycle memory latency with 2 outstanding and redirect_pc=32'h100: both stale responses dropped; next if_pc=32'h100.
REQ-036 SHALL test redirect_pc=32'h203: fetch address 32'h200.
REQ-037 SHALL test RESET_PC=32'hFFFF_FFF8: fetch addresses ...F8, ...FC, 0, 4.
REQ-038 SHALL test mid-stream reset with buffer full: next cycle if_valid=0, imem_req_valid=0; under FETCH_PERF_CNT_EN, perf_fetched=0.
